// File: rtl/whackamole_pkg.sv
// Shared definitions for the whack-a-mole game controller.
//   state_e           : game sequencer states
//   LFSR_TAPS         : feedback tap mask for x^8+x^6+x^5+x^4+1
//   DEFAULT_NUM_MOLES : default mole/button count
//   SCORE_W           : width of the score output
package whackamole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GAP  = 3'd2,
    ST_UP   = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  // Stages 8,6,5,4 of a left-shifting register map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEFAULT_NUM_MOLES = 4;
  localparam int SCORE_W = 7;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick which mole pops up.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, loads SEED
//   q     : current register value (advances every clock, never zero)
module mole_lfsr
  import whackamole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic fb;

  // XOR of the tapped bits; a non-zero seed keeps the register out of zero.
  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole game sequencer.
// Arms the countdown timer, schedules pseudo-random mole pop-ups, scores
// correct hits and freezes play when the timer reports game over.
// Ports:
//   clk             : system clock
//   rst_n           : asynchronous active-low reset
//   tick            : one-cycle time-base pulse
//   start           : one-cycle debounced start pulse
//   hit             : one-cycle debounced button pulses, one per mole
//   timer_game_over : game_over from the countdown timer
//   timer_restart   : restart_game request to the countdown timer
//   mole            : one-hot lit mole, zero when dark
//   score           : saturating hit count
//   playing         : high while a round is running (GAP/UP)
//   game_over       : high once the timer has ended the round (OVER)
// Handshake with the timer: timer_restart stays high until the timer
// drops timer_game_over, which confirms it has reloaded; only then does
// play start and timer_restart fall.
// All outputs are registered. The internal `state` register is the
// sequencer's observable state for checkers.
module whackamole_game_ctrl
  import whackamole_pkg::*;
#(
  parameter int         NUM_MOLES  = DEFAULT_NUM_MOLES,
  parameter int         MOLE_TICKS = 750,
  parameter int         GAP_TICKS  = 250,
  parameter int         SCORE_MAX  = 99,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit,
  input  logic                 timer_game_over,
  output logic                 timer_restart,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic                 playing,
  output logic                 game_over
);

  localparam int IDX_W  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int MAX_TK = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int CNT_W  = $clog2(MAX_TK + 1);

  localparam logic [CNT_W-1:0]   MOLE_LOAD = CNT_W'(MOLE_TICKS);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
  // With a single mole the index must always be zero.
  localparam logic [IDX_W-1:0]   IDX_MASK  = IDX_W'(NUM_MOLES - 1);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           lfsr_q;
  logic [IDX_W-1:0]     mole_idx;
  logic [NUM_MOLES-1:0] next_mole;
  logic                 mole_hit;
  logic                 in_play;
  logic                 lfsr_unused;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign mole_idx  = lfsr_q[IDX_W-1:0] & IDX_MASK;
  assign next_mole = NUM_MOLES'(1) << mole_idx;
  // mole is one-hot, so any overlap with hit means the lit button was pressed,
  // regardless of what else was pressed alongside it.
  assign mole_hit  = |(hit & mole);
  assign in_play   = (state == ST_GAP) || (state == ST_UP);
  // Upper LFSR bits only add randomness to the register itself.
  assign lfsr_unused = ^lfsr_q[7:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mole          <= '0;
      score         <= '0;
      timer_restart <= 1'b1;
      playing       <= 1'b0;
      game_over     <= 1'b0;
    end else if (in_play && timer_game_over) begin
      // Timer end outranks any same-cycle hit or tick.
      state     <= ST_OVER;
      mole      <= '0;
      playing   <= 1'b0;
      game_over <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            score <= '0;
            state <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (!timer_game_over) begin
            state         <= ST_GAP;
            cnt           <= GAP_LOAD;
            timer_restart <= 1'b0;
            playing       <= 1'b1;
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (cnt == CNT_ONE) begin
              state <= ST_UP;
              mole  <= next_mole;
              cnt   <= MOLE_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        ST_UP: begin
          if (mole_hit) begin
            // A hit beats an expiry tick arriving in the same cycle.
            if (score < SCORE_TOP) begin
              score <= score + SCORE_W'(1);
            end
            mole  <= '0;
            state <= ST_GAP;
            cnt   <= GAP_LOAD;
          end else if (tick) begin
            if (cnt == CNT_ONE) begin
              mole  <= '0;
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        ST_OVER: begin
          if (start) begin
            score         <= '0;
            state         <= ST_ARM;
            timer_restart <= 1'b1;
            game_over     <= 1'b0;
          end
        end

        default: begin
          state         <= ST_IDLE;
          mole          <= '0;
          timer_restart <= 1'b1;
          playing       <= 1'b0;
          game_over     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Self-checking bench for whackamole_game_ctrl with MOLE_TICKS=4,
// GAP_TICKS=2, a tick every 4 clocks and a behavioural countdown-timer model.
module tb_whackamole_game_ctrl;

  localparam int NM = 4;
  localparam int MT = 4;
  localparam int GT = 2;
  localparam int SMAX = 99;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic [NM-1:0] hit = '0;
  logic          tgo;
  logic          timer_restart;
  logic [NM-1:0] mole;
  logic [6:0]    score;
  logic          playing;
  logic          game_over;

  always #5 clk = ~clk;

  whackamole_game_ctrl #(
    .NUM_MOLES  (NM),
    .MOLE_TICKS (MT),
    .GAP_TICKS  (GT),
    .SCORE_MAX  (SMAX),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .start           (start),
    .hit             (hit),
    .timer_game_over (tgo),
    .timer_restart   (timer_restart),
    .mole            (mole),
    .score           (score),
    .playing         (playing),
    .game_over       (game_over)
  );

  // ---------------- environment models ----------------
  int   div = 0;
  int   run_cnt = 0;
  int   timer_limit = 100000;
  logic tgo_model = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  int   edge_cnt = 0;

  assign tgo = force_en ? force_val : tgo_model;

  // Tick every 4 clocks; timer raises game over after timer_limit clocks of
  // play and drops it one cycle after a restart request is seen.
  always @(negedge clk) begin
    div  = (div + 1) % 4;
    tick = (div == 0);
    if (timer_restart === 1'b1) begin
      run_cnt   = 0;
      tgo_model = 1'b0;
    end else begin
      run_cnt++;
      if (run_cnt >= timer_limit) tgo_model = 1'b1;
    end
  end

  // Clock edges since reset release: the LFSR value used at edge k is
  // the seed stepped k times.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // ---------------- scoreboard state ----------------
  int            tests_run = 0;
  int            fails = 0;
  int            model_score = 0;
  logic [6:0]    exp_q[$];
  logic [NM-1:0] cur_exp = '0;

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  // Waits for a mole to light; returns the mole the LFSR rule predicts.
  task automatic wait_mole(input int limit, output bit ok, output logic [NM-1:0] exp_m);
    logic [7:0] v;
    ok = 1'b0;
    exp_m = '0;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (mole !== '0) begin
        ok = 1'b1;
        v = lfsr_at(edge_cnt - 1);
        exp_m = NM'(1) << v[1:0];
        break;
      end
    end
  endtask

  function automatic int idx_of(input logic [NM-1:0] m);
    int r;
    r = 0;
    for (int i = 0; i < NM; i++) if (m[i]) r = i;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    tests_run++; if (timer_restart !== 1'b1) begin fails++; $display("FAIL reset_timer_restart: got %b want 1", timer_restart); end
    tests_run++; if (mole !== '0) begin fails++; $display("FAIL reset_mole: got %b want 0", mole); end
    tests_run++; if (score !== 7'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", score); end
    tests_run++; if (playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %b want 0", playing); end
    tests_run++; if (game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    rst_n = 1'b1;
    repeat (3) cycle();
    tests_run++; if (timer_restart !== 1'b1 || playing !== 1'b0) begin fails++; $display("FAIL idle_hold: got restart=%b playing=%b want 1/0", timer_restart, playing); end
  endtask

  task automatic test_first_mole();
    int ticks;
    bit ok;
    logic t;
    logic [7:0] v;
    logic [NM-1:0] e;
    start = 1'b1; cycle(); start = 1'b0;
    tests_run++; if (timer_restart !== 1'b1 || playing !== 1'b0) begin fails++; $display("FAIL arm_state: got restart=%b playing=%b want 1/0", timer_restart, playing); end
    cycle();
    tests_run++; if (timer_restart !== 1'b0 || playing !== 1'b1 || mole !== '0) begin fails++; $display("FAIL gap_entry: got restart=%b playing=%b mole=%b want 0/1/0", timer_restart, playing, mole); end
    ticks = 0; ok = 1'b0; t = 1'b0; e = '0;
    for (int i = 0; i < 40; i++) begin
      t = tick;
      cycle();
      if (t) ticks++;
      if (mole !== '0) begin
        ok = 1'b1;
        v = lfsr_at(edge_cnt - 1);
        e = NM'(1) << v[1:0];
        break;
      end
    end
    tests_run++; if (!ok) begin fails++; $display("FAIL first_mole_timeout: got no mole want mole within 40 cycles"); end
    tests_run++; if (ticks != GT || t !== 1'b1) begin fails++; $display("FAIL first_mole_ticks: got %0d ticks want %0d", ticks, GT); end
    tests_run++; if (mole !== e) begin fails++; $display("FAIL first_mole_value: got %b want %b", mole, e); end
    tests_run++; if (score !== 7'(model_score)) begin fails++; $display("FAIL first_mole_score: got %0d want %0d", score, model_score); end
    cur_exp = e;
  endtask

  task automatic test_hit();
    int w;
    bit ok;
    logic [NM-1:0] e;
    logic [6:0] want;
    w = (idx_of(cur_exp) + int'($urandom_range(1, NM - 1))) % NM;
    hit = NM'(1) << w; cycle(); hit = '0;
    tests_run++; if (score !== 7'(model_score)) begin fails++; $display("FAIL wrong_hit_score: got %0d want %0d", score, model_score); end
    tests_run++; if (mole !== cur_exp) begin fails++; $display("FAIL wrong_hit_mole: got %b want %b", mole, cur_exp); end
    repeat ($urandom_range(0, 2)) cycle();
    hit = cur_exp; cycle(); hit = '0;
    model_score++; exp_q.push_back(7'(model_score));
    want = exp_q.pop_front();
    tests_run++; if (score !== want) begin fails++; $display("FAIL correct_hit_score: got %0d want %0d", score, want); end
    tests_run++; if (mole !== '0 || playing !== 1'b1) begin fails++; $display("FAIL correct_hit_clear: got mole=%b playing=%b want 0/1", mole, playing); end
    wait_mole(60, ok, e);
    tests_run++; if (!ok || mole !== e) begin fails++; $display("FAIL second_mole: got %b want %b", mole, e); end
    // Correct button together with every other button scores once.
    hit = '1; cycle(); hit = '0;
    model_score++; exp_q.push_back(7'(model_score));
    want = exp_q.pop_front();
    tests_run++; if (score !== want || mole !== '0) begin fails++; $display("FAIL multi_hit: got score=%0d mole=%b want %0d/0", score, mole, want); end
  endtask

  task automatic test_expiry();
    int ticks;
    bit ok;
    bit fired;
    logic t;
    logic [NM-1:0] e;
    wait_mole(60, ok, e);
    tests_run++; if (!ok || mole !== e) begin fails++; $display("FAIL expiry_mole: got %b want %b", mole, e); end
    ticks = 0; ok = 1'b0; t = 1'b0;
    for (int i = 0; i < 60; i++) begin
      t = tick;
      cycle();
      if (t) ticks++;
      if (mole === '0) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok || ticks != MT || t !== 1'b1) begin fails++; $display("FAIL expiry_ticks: got %0d ticks want %0d", ticks, MT); end
    tests_run++; if (score !== 7'(model_score)) begin fails++; $display("FAIL expiry_score: got %0d want %0d", score, model_score); end
    wait_mole(60, ok, e);
    tests_run++; if (!ok || mole !== e) begin fails++; $display("FAIL expiry2_mole: got %b want %b", mole, e); end
    ticks = 0; fired = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tick) begin
        if (ticks == MT - 1) begin hit = e; fired = 1'b1; end
        ticks++;
      end
      cycle();
      hit = '0;
      if (fired) break;
    end
    if (fired) model_score++;
    tests_run++; if (!fired || score !== 7'(model_score) || mole !== '0) begin fails++; $display("FAIL hit_on_expiry: got score=%0d mole=%b want %0d/0", score, mole, model_score); end
  endtask

  task automatic test_over_and_arm();
    bit ok;
    logic [NM-1:0] e;
    wait_mole(60, ok, e);
    tests_run++; if (!ok) begin fails++; $display("FAIL over_mole_timeout: got no mole want lit mole"); end
    repeat ($urandom_range(0, 2)) cycle();
    force_en = 1'b1; force_val = 1'b1; hit = e; cycle(); hit = '0;
    tests_run++; if (game_over !== 1'b1 || playing !== 1'b0 || mole !== '0) begin fails++; $display("FAIL over_entry: got go=%b playing=%b mole=%b want 1/0/0", game_over, playing, mole); end
    tests_run++; if (score !== 7'(model_score) || timer_restart !== 1'b0) begin fails++; $display("FAIL over_score: got score=%0d restart=%b want %0d/0", score, timer_restart, model_score); end
    repeat (3) cycle();
    tests_run++; if (game_over !== 1'b1 || score !== 7'(model_score)) begin fails++; $display("FAIL over_hold: got go=%b score=%0d want 1/%0d", game_over, score, model_score); end
    start = 1'b1; cycle(); start = 1'b0;
    model_score = 0;
    tests_run++; if (score !== 7'd0 || timer_restart !== 1'b1 || game_over !== 1'b0 || playing !== 1'b0) begin fails++; $display("FAIL restart_arm: got score=%0d restart=%b go=%b playing=%b want 0/1/0/0", score, timer_restart, game_over, playing); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++; if (timer_restart !== 1'b1 || playing !== 1'b0) begin fails++; $display("FAIL arm_hold_%0d: got restart=%b playing=%b want 1/0", i, timer_restart, playing); end
    end
    force_en = 1'b0;
    cycle();
    tests_run++; if (playing !== 1'b1 || timer_restart !== 1'b0) begin fails++; $display("FAIL arm_release: got playing=%b restart=%b want 1/0", playing, timer_restart); end
    start = 1'b1; cycle(); start = 1'b0;
    tests_run++; if (playing !== 1'b1 || timer_restart !== 1'b0 || score !== 7'(model_score)) begin fails++; $display("FAIL start_ignored: got playing=%b restart=%b score=%0d want 1/0/%0d", playing, timer_restart, score, model_score); end
  endtask

  task automatic test_timer_end();
    bit ok;
    int n;
    timer_limit = 200;
    ok = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (game_over === 1'b1) begin ok = 1'b1; n = i; break; end
    end
    tests_run++; if (!ok || n < 150) begin fails++; $display("FAIL timer_end: got ok=%b after %0d cycles want ~200", ok, n); end
    tests_run++; if (playing !== 1'b0 || mole !== '0 || score !== 7'(model_score)) begin fails++; $display("FAIL timer_end_outputs: got playing=%b mole=%b score=%0d want 0/0/%0d", playing, mole, score, model_score); end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [NM-1:0] e;
    logic [6:0] want;
    timer_limit = 100000;
    start = 1'b1; cycle(); start = 1'b0;
    model_score = 0;
    tests_run++; if (score !== 7'd0) begin fails++; $display("FAIL sat_start_score: got %0d want 0", score); end
    for (int k = 0; k < SMAX + 2; k++) begin
      wait_mole(60, ok, e);
      tests_run++; if (!ok || mole !== e) begin fails++; $display("FAIL sat_mole_%0d: got %b want %b", k, mole, e); end
      if (!ok) break;
      repeat ($urandom_range(0, 2)) cycle();
      hit = e; cycle(); hit = '0;
      model_score = (model_score < SMAX) ? model_score + 1 : SMAX;
      exp_q.push_back(7'(model_score));
      want = exp_q.pop_front();
      tests_run++; if (score !== want) begin fails++; $display("FAIL sat_score_%0d: got %0d want %0d", k, score, want); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_first_mole();
    test_hit();
    test_expiry();
    test_over_and_arm();
    test_timer_end();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
